// File: rtl/sobel_pkg.sv
// Shared constants for the streaming Sobel edge detector:
// direction codes, angle-bin tangent ratios and gradient width.
package sobel_pkg;

    localparam logic [1:0] DIR_0   = 2'd0;
    localparam logic [1:0] DIR_45  = 2'd1;
    localparam logic [1:0] DIR_90  = 2'd2;
    localparam logic [1:0] DIR_135 = 2'd3;

    // tan(22.5deg) ~ 2/5 and tan(67.5deg) ~ 5/2 split the angle bins
    localparam int TAN_LO_NUM = 2;
    localparam int TAN_LO_DEN = 5;
    localparam int TAN_HI_NUM = 5;
    localparam int TAN_HI_DEN = 2;

    // signed gradient width: 4*max pixel plus sign
    function automatic int grad_w(input int data_w);
        return data_w + 3;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-line delay RAM feeding a 3x3 sliding window.
// Row 0 of the window is the oldest line, column 2 the newest pixel.
module sobel_line_buffer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int CW     = $clog2(IMG_W)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        shift_i,
    input  logic [CW-1:0]               col_i,
    input  logic [DATA_W-1:0]           data_i,
    output logic [2:0][2:0][DATA_W-1:0] win_o
);

    logic [DATA_W-1:0]           line0_q [IMG_W];
    logic [DATA_W-1:0]           line1_q [IMG_W];
    logic [DATA_W-1:0]           up1;
    logic [DATA_W-1:0]           up2;
    logic [2:0][2:0][DATA_W-1:0] win_q;

    assign up1   = line0_q[col_i];
    assign up2   = line1_q[col_i];
    assign win_o = win_q;

    // line RAMs: old column read out before being overwritten
    always_ff @(posedge clk) begin
        if (shift_i) begin
            line0_q[col_i] <= data_i;
            line1_q[col_i] <= up1;
        end
    end

    // window shifts left; new column enters on the right
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
        end else if (shift_i) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= up2;
            win_q[1][2] <= up1;
            win_q[2][2] <= data_i;
        end
    end

endmodule

// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge detector with valid/ready flow control.
// Stages: window shift, gradients, magnitude/direction/threshold.
module sobel_stream_filter
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_sof,
    input  logic              mag_mode,
    input  logic [DATA_W-1:0] thresh,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_mag,
    output logic [1:0]        m_dir,
    output logic              m_edge,
    output logic              m_eol,
    output logic              m_eof
);

    localparam int GW = grad_w(DATA_W);
    localparam int PW = GW + 3;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0]     COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(IMG_H - 1);
    localparam logic [DATA_W-1:0] MAG_MAX  = '1;

    logic                        en;
    logic                        acc;
    logic [CW-1:0]               col_q, col_d, col_cur;
    logic [RW-1:0]               row_q, row_d, row_cur;
    logic [DATA_W-1:0]           thr_q;
    logic [2:0][2:0][DATA_W-1:0] win;
    logic                        v0_q, b0_q, eol0_q, eof0_q;
    logic                        v1_q, b1_q, eol1_q, eof1_q;
    logic [GW-1:0]               rc, lc, tr, br;
    logic [GW-1:0]               gx_d, gy_d, gx_q, gy_q;
    logic [GW-1:0]               ax, ay, amax, amin, raw;
    logic [PW-1:0]               axp, ayp;
    logic [DATA_W-1:0]           mag_d;
    logic [1:0]                  dir_d;
    logic                        edge_d;
    logic                        m_valid_q, m_edge_q;
    logic                        m_eol_q, m_eof_q;
    logic [DATA_W-1:0]           m_mag_q;
    logic [1:0]                  m_dir_q;

    assign en      = !m_valid_q || m_ready;
    assign acc     = s_valid && en;
    assign s_ready = en;

    assign m_valid = m_valid_q;
    assign m_mag   = m_mag_q;
    assign m_dir   = m_dir_q;
    assign m_edge  = m_edge_q;
    assign m_eol   = m_eol_q;
    assign m_eof   = m_eof_q;

    function automatic logic [GW-1:0] px(input logic [DATA_W-1:0] p);
        return GW'(p);
    endfunction

    // raster position of this beat; SOF restarts the frame at (0,0)
    always_comb begin
        row_cur = s_sof ? '0 : row_q;
        col_cur = s_sof ? '0 : col_q;
        row_d   = row_q;
        col_d   = col_q;
        if (acc) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
        end
    end

    // position counters and frame threshold captured with SOF
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= '0;
            col_q <= '0;
            thr_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
            if (acc && s_sof) begin
                thr_q <= thresh;
            end
        end
    end

    sobel_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W),
        .CW     (CW)
    ) u_lb (
        .clk     (clk),
        .rst_n   (rst_n),
        .shift_i (acc),
        .col_i   (col_cur),
        .data_i  (s_data),
        .win_o   (win)
    );

    // S0: tag the freshly shifted window with border and eol/eof
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0_q   <= 1'b0;
            b0_q   <= 1'b0;
            eol0_q <= 1'b0;
            eof0_q <= 1'b0;
        end else if (en) begin
            v0_q <= s_valid;
            if (s_valid) begin
                b0_q   <= (row_cur < RW'(2)) || (col_cur < CW'(2));
                eol0_q <= (col_cur == COL_LAST);
                eof0_q <= (col_cur == COL_LAST) && (row_cur == ROW_LAST);
            end
        end
    end

    // gradient adder tree, weights 1,2,1 on opposing edges
    always_comb begin
        rc   = px(win[0][2]) + (px(win[1][2]) << 1) + px(win[2][2]);
        lc   = px(win[0][0]) + (px(win[1][0]) << 1) + px(win[2][0]);
        tr   = px(win[0][0]) + (px(win[0][1]) << 1) + px(win[0][2]);
        br   = px(win[2][0]) + (px(win[2][1]) << 1) + px(win[2][2]);
        gx_d = rc - lc;
        gy_d = tr - br;
    end

    // S1: gradient register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            b1_q   <= 1'b0;
            eol1_q <= 1'b0;
            eof1_q <= 1'b0;
            gx_q   <= '0;
            gy_q   <= '0;
        end else if (en) begin
            v1_q   <= v0_q;
            b1_q   <= b0_q;
            eol1_q <= eol0_q;
            eof1_q <= eof0_q;
            gx_q   <= gx_d;
            gy_q   <= gy_d;
        end
    end

    // magnitude with saturation, 4-bin direction, threshold compare
    always_comb begin
        ax    = gx_q[GW-1] ? -gx_q : gx_q;
        ay    = gy_q[GW-1] ? -gy_q : gy_q;
        amax  = (ax >= ay) ? ax : ay;
        amin  = (ax >= ay) ? ay : ax;
        raw   = mag_mode ? amax + (amin >> 1) : ax + ay;
        mag_d = (raw > {3'b000, MAG_MAX}) ? MAG_MAX : raw[DATA_W-1:0];
        axp   = PW'(ax);
        ayp   = PW'(ay);
        if (PW'(TAN_LO_DEN) * ayp <= PW'(TAN_LO_NUM) * axp) begin
            dir_d = DIR_0;
        end else if (PW'(TAN_HI_DEN) * ayp >= PW'(TAN_HI_NUM) * axp) begin
            dir_d = DIR_90;
        end else if (gx_q[GW-1] == gy_q[GW-1]) begin
            dir_d = DIR_45;
        end else begin
            dir_d = DIR_135;
        end
        edge_d = (mag_d >= thr_q);
    end

    // S2: output register; border windows report zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_mag_q   <= '0;
            m_dir_q   <= DIR_0;
            m_edge_q  <= 1'b0;
            m_eol_q   <= 1'b0;
            m_eof_q   <= 1'b0;
        end else if (en) begin
            m_valid_q <= v1_q;
            m_mag_q   <= b1_q ? '0 : mag_d;
            m_dir_q   <= b1_q ? DIR_0 : dir_d;
            m_edge_q  <= !b1_q && edge_d;
            m_eol_q   <= eol1_q;
            m_eof_q   <= eof1_q;
        end
    end

endmodule
